dma_bus_arbiter: RTL
====================

// Module: dma_bus_arbiter
// PURPOSE
//  Shares the 6502C external address bus between the CPU and NUM_REQ DMA requesters
//  (ANTIC display-list/playfield fetch, memory refresh).
//  - Halts the CPU through its RDY input.
//  - Grants the bus to the highest-priority requester and muxes AB/RW.
//  - Returns the bus to the CPU for at least one cycle after every burst.
//  Sits between the 6502C top-level pins (AB, RW, RDY) and the system memory bus.
// PARAMETERS
//  NUM_REQ    3   number of DMA requesters; index 0 has the highest priority
//  MAX_BURST  8   maximum consecutive DMA cycles before the bus is forced back to the CPU
// PORTS
//  phi2      in   1          system clock; all state changes on posedge phi2
//  RES_L     in   1          asynchronous active-low reset
//  cpu_AB    in   16         CPU address bus
//  cpu_RW    in   1          CPU read/write (1 = read)
//  dma_req   in   NUM_REQ    per-requester request; held high while cycles are wanted
//  dma_addr  in   16*NUM_REQ packed requester addresses; [16*i+15:16*i] belongs to requester i
//  RDY_out   out  1          to CPU RDY pin; 0 = halt CPU
//  dma_gnt   out  NUM_REQ    one-hot grant; requester i owns the current bus cycle
//  AB_out    out  16         system address bus
//  RW_out    out  1          system read/write
//  dma_busy  out  1          1 while in HALT_WAIT or GRANT
// BEHAVIOUR
//  Reset (async, RES_L=0):
//  - state=CPU_OWN, RDY_out=1, dma_gnt=0, burst_cnt=0, dma_busy=0.
//  - Reset takes effect immediately, including mid-burst.
//  Registers and outputs:
//  - RDY_out, dma_gnt and state are registered.
//  - AB_out/RW_out are combinational: dma_gnt!=0 selects dma_addr[winner] with RW_out=1
//    (DMA is read-only); otherwise cpu_AB/cpu_RW.
//  States:
//  - CPU_OWN: RDY_out=1, gnt=0.
//    If |dma_req -> HALT_WAIT (RDY_out=0 from the next cycle).
//  - HALT_WAIT: RDY_out=0, gnt=0.
//    The 6502 honours RDY only on read cycles; writes (up to 3, e.g. BRK/IRQ pushes) are
//    passed through to the bus.
//    On an edge with cpu_RW=1 (CPU now stalled) -> GRANT.
//    If dma_req drops to 0 first -> CPU_OWN.
//  - GRANT: RDY_out=0, dma_gnt = one-hot of the lowest set index of dma_req.
//    Priority is re-evaluated every cycle, so a higher-priority request pre-empts at the
//    next edge. burst_cnt increments each GRANT cycle.
//    If dma_req==0 or burst_cnt==MAX_BURST-1 -> RELEASE.
//  - RELEASE: RDY_out=1, gnt=0, burst_cnt cleared, for exactly one cycle; then CPU_OWN
//    unconditionally.
//    This guarantees at least 2 consecutive CPU cycles between bursts (RELEASE plus the
//    CPU_OWN evaluation cycle).
//  Latency and arbitration rules:
//  - Minimum latency from dma_req rising (sampled in CPU_OWN) to dma_gnt: 2 edges.
//  - A requester whose dma_req drops while granted loses its grant at the next edge.
//  - Simultaneous requests: the lowest index wins; others wait in GRANT, or in the next
//    burst if MAX_BURST is hit.
//  - burst_cnt width is $clog2(MAX_BURST); it saturates and never wraps.
//  - dma_addr of non-granted requesters is ignored.
//  - X/Z on a non-granted requester's address must not reach AB_out.
// STRUCTURE
//  - Package dma_arb_pkg holds:
//    - the state enum {CPU_OWN, HALT_WAIT, GRANT, RELEASE} (2-bit encoding);
//    - default NUM_REQ/MAX_BURST constants;
//    - a localparam for the read value of RW (1).
//  - Sub-module prio_onehot_enc (NUM_REQ): lowest-index-first one-hot encoder plus
//    index output for the address mux.
//  - Top level holds the FSM, burst counter and AB/RW mux.
// TESTING
//  1. Reset:
//     - Assert RES_L=0 mid-GRANT -> RDY_out=1 and dma_gnt=0 within the same cycle.
//     - AB_out follows cpu_AB (0x1234).
//  2. Single request:
//     - dma_req=3'b010 with CPU reading -> RDY_out=0 at edge 1, dma_gnt=3'b010 at edge 2.
//     - AB_out=dma_addr[1] (0xD400), RW_out=1.
//  3. Write stall:
//     - Raise dma_req=3'b001 while the CPU performs 3 writes (cpu_RW=0) -> gnt stays 0,
//       writes pass through with RW_out=0.
//     - Grant is issued on the edge after the first cpu_RW=1 cycle.
//  4. Priority pre-emption:
//     - Grant to req[2], then raise req[0] -> dma_gnt becomes 3'b001 at the next edge.
//     - Grant returns to 3'b100 when req[0] drops.
//  5. Burst limit:
//     - Hold dma_req=3'b001 continuously, MAX_BURST=8 -> exactly 8 GRANT cycles, then
//       RDY_out=1 for 2 cycles, then HALT_WAIT again.
//  6. Request withdrawn:
//     - Drop dma_req to 0 while in HALT_WAIT -> back to CPU_OWN, RDY_out=1 next edge,
//       no grant ever asserted.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the 6502C DMA bus arbiter.
// Holds the arbiter state encoding, default sizing and the RW read level.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HALT_WAIT = 2'd1,
    GRANT     = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  localparam int   DEF_NUM_REQ   = 3;
  localparam int   DEF_MAX_BURST = 8;
  localparam logic RW_READ       = 1'b1;

  // Width helper that never returns zero, so single-entry sizes still get a 1-bit field.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_onehot_enc.sv
// Lowest-index-first priority encoder.
// Produces a one-hot winner, its binary index and an any-request flag.
module prio_onehot_enc #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scanning from the top down lets the lowest set index overwrite any higher one.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the 6502C address bus between the CPU and NUM_REQ read-only DMA requesters.
// Halts the CPU via RDY, grants bursts of up to MAX_BURST cycles, then returns the bus.
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                   phi2,
  input  logic                   RES_L,
  input  logic [15:0]            cpu_AB,
  input  logic                   cpu_RW,
  input  logic [NUM_REQ-1:0]     dma_req,
  input  logic [16*NUM_REQ-1:0]  dma_addr,
  output logic                   RDY_out,
  output logic [NUM_REQ-1:0]     dma_gnt,
  output logic [15:0]            AB_out,
  output logic                   RW_out,
  output logic                   dma_busy
);

  localparam int IDX_W = safe_clog2(NUM_REQ);
  localparam int CNT_W = safe_clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e         state_q;
  logic               rdy_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [CNT_W-1:0]   burst_cnt_q;
  logic [CNT_W-1:0]   burst_cnt_d;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               req_any;
  logic               burst_last;

  prio_onehot_enc #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i    (dma_req),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .any_o    (req_any)
  );

  assign burst_last  = (burst_cnt_q == CNT_LAST);
  assign burst_cnt_d = burst_last ? burst_cnt_q : burst_cnt_q + CNT_W'(1);

  always_ff @(posedge phi2 or negedge RES_L) begin
    if (!RES_L) begin
      state_q     <= CPU_OWN;
      rdy_q       <= 1'b1;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        CPU_OWN: begin
          if (req_any) begin
            state_q <= HALT_WAIT;
            rdy_q   <= 1'b0;
          end
        end
        HALT_WAIT: begin
          // Writes ignore RDY, so the grant waits for the first read cycle.
          if (!req_any) begin
            state_q <= CPU_OWN;
            rdy_q   <= 1'b1;
          end else if (cpu_RW == RW_READ) begin
            state_q   <= GRANT;
            gnt_q     <= win_onehot;
            gnt_idx_q <= win_idx;
          end
        end
        GRANT: begin
          if (!req_any || burst_last) begin
            state_q     <= RELEASE;
            rdy_q       <= 1'b1;
            gnt_q       <= '0;
            burst_cnt_q <= '0;
          end else begin
            gnt_q       <= win_onehot;
            gnt_idx_q   <= win_idx;
            burst_cnt_q <= burst_cnt_d;
          end
        end
        RELEASE: begin
          state_q     <= CPU_OWN;
          burst_cnt_q <= '0;
        end
        default: begin
          state_q     <= CPU_OWN;
          rdy_q       <= 1'b1;
          gnt_q       <= '0;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

  // Only the granted slice is ever selected, so unknowns on idle requesters stay off the bus.
  logic [15:0] addr_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = dma_addr[16*gi +: 16];
    end
  endgenerate

  assign AB_out   = (|gnt_q) ? addr_arr[gnt_idx_q] : cpu_AB;
  assign RW_out   = (|gnt_q) ? RW_READ : cpu_RW;
  assign RDY_out  = rdy_q;
  assign dma_gnt  = gnt_q;
  assign dma_busy = (state_q == HALT_WAIT) || (state_q == GRANT);

endmodule
